// File: rtl/tanhx_share_ctrl_if.sv
// Requester handshakes and the link to the shared tanh unit.
// master = clients plus unit side, slave = the sharing controller.
interface tanhx_share_ctrl_if #(
    parameter int N      = 4,
    parameter int DWIDTH = 32
);
    logic [N-1:0]        req_valid;
    logic [N*DWIDTH-1:0] req_data;
    logic [N-1:0]        req_ready;
    logic [N-1:0]        rsp_valid;
    logic [N*DWIDTH-1:0] rsp_data;
    logic [N-1:0]        rsp_ready;
    logic                u_start;
    logic [DWIDTH-1:0]   u_x;
    logic [DWIDTH-1:0]   u_y;
    logic                u_valid;
    logic                busy;
    logic                err;

    modport master (
        output req_valid, req_data, rsp_ready, u_y, u_valid,
        input  req_ready, rsp_valid, rsp_data, u_start, u_x, busy, err
    );

    modport slave (
        input  req_valid, req_data, rsp_ready, u_y, u_valid,
        output req_ready, rsp_valid, rsp_data, u_start, u_x, busy, err
    );
endinterface

// File: rtl/tanhx_share_ctrl.sv
// Shares one pipelined tanh unit among N requesters: round-robin issue,
// warm-up sequencing, tag tracking and per-requester result FIFOs.
module tanhx_share_ctrl #(
    parameter int N      = 4,
    parameter int DWIDTH = 32,
    parameter int LAT    = 4,
    parameter int WARM   = 2,
    parameter int DEPTH  = 4
) (
    input logic            clk,
    input logic            rst,
    tanhx_share_ctrl_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW = (WARM > 1) ? $clog2(WARM) : 1;
    localparam logic [PW-1:0] LASTP = PW'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN, S_DRAIN} state_t;

    state_t            state;
    logic [WW-1:0]     warm_cnt;
    logic [IW-1:0]     last_grant;
    logic [CW-1:0]     credit [N];
    logic [N-1:0]      elig;
    logic [N-1:0]      grant;
    logic [N-1:0]      pop;
    logic [N-1:0]      wr;
    logic              gnt_any;
    logic [IW-1:0]     gnt_idx;
    logic [LAT-1:0]    tv;
    logic [IW-1:0]     ti [LAT];
    logic [DWIDTH-1:0] mem [N][DEPTH];
    logic [PW-1:0]     wptr [N];
    logic [PW-1:0]     rptr [N];
    logic [CW-1:0]     cnt [N];
    logic              drain_empty;
    logic              err_q;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            elig[i] = bus.req_valid[i] && (credit[i] < CW'(DEPTH));
            pop[i]  = bus.rsp_ready[i] && (cnt[i] != '0);
            wr[i]   = tv[LAT-1] && (ti[LAT-1] == IW'(i));
        end
    end

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        int idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(last_grant) + 1 + k) % N;
            if (!rst && (state == S_RUN || state == S_DRAIN)
                && !gnt_any && elig[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(idx);
            end
        end
    end

    // The newest tag enters stage 0; the one in the last stage is consumed now.
    always_comb begin
        drain_empty = 1'b1;
        for (int k = 0; k < LAT - 1; k++) begin
            if (tv[k]) drain_empty = 1'b0;
        end
    end

    always_comb begin
        bus.rsp_data = '0;
        for (int i = 0; i < N; i++) begin
            bus.rsp_valid[i] = (cnt[i] != '0);
            if (cnt[i] != '0) bus.rsp_data[i*DWIDTH +: DWIDTH] = mem[i][rptr[i]];
        end
    end

    assign grant         = gnt_any ? (N'(1) << gnt_idx) : '0;
    assign bus.req_ready = grant;
    assign bus.u_x       = gnt_any ? bus.req_data[int'(gnt_idx)*DWIDTH +: DWIDTH] : '0;
    assign bus.u_start   = (state != S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.err       = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            warm_cnt   <= '0;
            last_grant <= IW'(N - 1);
            tv         <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                credit[i] <= '0;
                cnt[i]    <= '0;
                wptr[i]   <= '0;
                rptr[i]   <= '0;
            end
        end else begin
            tv[0] <= gnt_any;
            ti[0] <= gnt_idx;
            for (int k = 1; k < LAT; k++) begin
                tv[k] <= tv[k-1];
                ti[k] <= ti[k-1];
            end
            if (gnt_any) last_grant <= gnt_idx;
            if (tv[LAT-1] && !bus.u_valid) err_q <= 1'b1;

            for (int i = 0; i < N; i++) begin
                if (grant[i] && !pop[i]) credit[i] <= credit[i] + 1'b1;
                else if (!grant[i] && pop[i]) credit[i] <= credit[i] - 1'b1;
                if (wr[i] && !pop[i]) cnt[i] <= cnt[i] + 1'b1;
                else if (!wr[i] && pop[i]) cnt[i] <= cnt[i] - 1'b1;
                if (wr[i]) begin
                    mem[i][wptr[i]] <= bus.u_y;
                    wptr[i] <= (wptr[i] == LASTP) ? '0 : wptr[i] + 1'b1;
                end
                if (pop[i]) rptr[i] <= (rptr[i] == LASTP) ? '0 : rptr[i] + 1'b1;
            end

            unique case (state)
                S_IDLE: begin
                    if (|elig) begin
                        warm_cnt <= '0;
                        state    <= (WARM == 0) ? S_RUN : S_WARM;
                    end
                end
                S_WARM: begin
                    if (warm_cnt == WW'(WARM - 1)) state <= S_RUN;
                    else warm_cnt <= warm_cnt + 1'b1;
                end
                S_RUN: begin
                    if (!gnt_any) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (gnt_any) state <= S_RUN;
                    else if (drain_empty) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tanhx_share_ctrl.sv
// Directed bench for tanhx_share_ctrl with a stub unit computing y = ~x
// over LAT stages; inputs change 1 time unit after posedge, checks at negedge.
module tb_tanhx_share_ctrl;
    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int LAT   = 4;
    localparam int WARM  = 2;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    logic kill;
    int   checks   = 0;
    int   failures = 0;

    tanhx_share_ctrl_if #(.N(N), .DWIDTH(DW)) bus ();

    tanhx_share_ctrl #(
        .N(N), .DWIDTH(DW), .LAT(LAT), .WARM(WARM), .DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0]  ux_p [LAT];
    logic [LAT-1:0] uv_p;

    always @(posedge clk) begin
        if (rst) begin
            uv_p <= '0;
            for (int k = 0; k < LAT; k++) ux_p[k] <= '0;
        end else begin
            uv_p    <= {uv_p[LAT-2:0], bus.u_start};
            ux_p[0] <= ~bus.u_x;
            for (int k = 1; k < LAT; k++) ux_p[k] <= ux_p[k-1];
        end
    end

    assign bus.u_y     = ux_p[LAT-1];
    assign bus.u_valid = uv_p[LAT-1] & ~kill;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst           = 1'b1;
        kill          = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = '0;
        step;
        step;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0) begin
            failures++; $display("FAIL reset_req_ready got %b want 0", bus.req_ready);
        end
        checks++;
        if (bus.rsp_valid !== 4'b0) begin
            failures++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid);
        end
        checks++;
        if (bus.rsp_data !== '0) begin
            failures++; $display("FAIL reset_rsp_data got %h want 0", bus.rsp_data);
        end
        checks++;
        if ({bus.u_start, bus.busy, bus.err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got start/busy/err=%b want 000",
                     {bus.u_start, bus.busy, bus.err});
        end
        checks++;
        if (bus.u_x !== '0) begin
            failures++; $display("FAIL reset_u_x got %h want 0", bus.u_x);
        end
    endtask

    task automatic test_single;
        do_reset;
        bus.req_valid[2]       = 1'b1;
        bus.req_data[2*DW +: DW] = 32'h3F80_0000;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0 || bus.u_start !== 1'b0) begin
            failures++;
            $display("FAIL single_idle got ready=%b start=%b want 0 0",
                     bus.req_ready, bus.u_start);
        end
        step;
        @(negedge clk);
        checks++;
        if (bus.u_start !== 1'b1 || bus.u_x !== '0 || bus.req_ready !== 4'b0) begin
            failures++;
            $display("FAIL single_warm got start=%b x=%h ready=%b want 1 0 0",
                     bus.u_start, bus.u_x, bus.req_ready);
        end
        step;
        step;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0100 || bus.u_x !== 32'h3F80_0000) begin
            failures++;
            $display("FAIL single_grant got ready=%b x=%h want 0100 3f800000",
                     bus.req_ready, bus.u_x);
        end
        step;
        bus.req_valid = '0;
        step;
        step;
        step;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 4'b0) begin
            failures++; $display("FAIL single_early_rsp got %b want 0", bus.rsp_valid);
        end
        step;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 4'b0100 || bus.rsp_data[2*DW +: DW] !== 32'hC07F_FFFF) begin
            failures++;
            $display("FAIL single_rsp got valid=%b data=%h want 0100 c07fffff",
                     bus.rsp_valid, bus.rsp_data[2*DW +: DW]);
        end
        checks++;
        if (bus.err !== 1'b0) begin
            failures++; $display("FAIL single_err got %b want 0", bus.err);
        end
        bus.rsp_ready[2] = 1'b1;
        step;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 4'b0) begin
            failures++; $display("FAIL single_pop got %b want 0", bus.rsp_valid);
        end
    endtask

    task automatic test_round_robin;
        int            recv [N];
        int            iss [N];
        logic [N-1:0]  g;
        logic [N-1:0]  want;
        logic [DW-1:0] exp_d;
        do_reset;
        for (int i = 0; i < N; i++) begin
            recv[i] = 0;
            iss[i]  = 0;
            bus.req_data[i*DW +: DW] = DW'(i * 256);
        end
        bus.req_valid = '1;
        bus.rsp_ready = '1;
        step;
        step;
        step;
        for (int k = 0; k < 22; k++) begin
            if (k == 12) bus.req_valid = '0;
            @(negedge clk);
            g = bus.req_ready;
            if (k < 12) begin
                want = N'(1) << (k % N);
                checks++;
                if (g !== want) begin
                    failures++; $display("FAIL rr_grant k=%0d got %b want %b", k, g, want);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (bus.rsp_valid[i]) begin
                    exp_d = ~DW'(i * 256 + recv[i]);
                    checks++;
                    if (bus.rsp_data[i*DW +: DW] !== exp_d) begin
                        failures++;
                        $display("FAIL rr_data req=%0d got %h want %h",
                                 i, bus.rsp_data[i*DW +: DW], exp_d);
                    end
                    recv[i]++;
                end
            end
            step;
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    iss[i]++;
                    bus.req_data[i*DW +: DW] = DW'(i * 256 + iss[i]);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (recv[i] !== 3) begin
                failures++; $display("FAIL rr_count req=%0d got %0d want 3", i, recv[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        int            g1 = 0;
        int            g3 = 0;
        int            pops = 0;
        int            iss1 = 0;
        int            iss3 = 0;
        logic          resumed = 1'b0;
        logic [N-1:0]  g;
        logic [DW-1:0] exp_d;
        do_reset;
        bus.req_valid = 4'b1010;
        bus.rsp_ready = 4'b1000;
        bus.req_data[1*DW +: DW] = 32'h100;
        bus.req_data[3*DW +: DW] = 32'h300;
        step;
        step;
        step;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            g = bus.req_ready;
            if (g[1]) g1++;
            if (g[3]) g3++;
            step;
            if (g[1]) begin iss1++; bus.req_data[1*DW +: DW] = DW'(32'h100 + iss1); end
            if (g[3]) begin iss3++; bus.req_data[3*DW +: DW] = DW'(32'h300 + iss3); end
        end
        @(negedge clk);
        checks++;
        if (g1 !== 4) begin
            failures++; $display("FAIL bp_grants1 got %0d want 4", g1);
        end
        checks++;
        if (g3 < 6) begin
            failures++; $display("FAIL bp_grants3 got %0d want >=6", g3);
        end
        checks++;
        if (bus.req_ready[1] !== 1'b0) begin
            failures++; $display("FAIL bp_stall got %b want 0", bus.req_ready[1]);
        end
        checks++;
        if (bus.rsp_valid[1] !== 1'b1 || bus.rsp_data[1*DW +: DW] !== ~32'h100) begin
            failures++;
            $display("FAIL bp_head got valid=%b data=%h want 1 %h",
                     bus.rsp_valid[1], bus.rsp_data[1*DW +: DW], ~32'h100);
        end
        step;
        bus.rsp_ready[1] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            g = bus.req_ready;
            if (g[1]) resumed = 1'b1;
            if (k < 5 && bus.rsp_valid[1]) begin
                exp_d = ~DW'(32'h100 + pops);
                checks++;
                if (bus.rsp_data[1*DW +: DW] !== exp_d) begin
                    failures++;
                    $display("FAIL bp_pop_data got %h want %h",
                             bus.rsp_data[1*DW +: DW], exp_d);
                end
                pops++;
            end
            step;
            if (g[1]) begin iss1++; bus.req_data[1*DW +: DW] = DW'(32'h100 + iss1); end
            if (g[3]) begin iss3++; bus.req_data[3*DW +: DW] = DW'(32'h300 + iss3); end
        end
        checks++;
        if (pops !== 4) begin
            failures++; $display("FAIL bp_pops got %0d want 4", pops);
        end
        checks++;
        if (resumed !== 1'b1) begin
            failures++; $display("FAIL bp_resume got %b want 1", resumed);
        end
    endtask

    task automatic test_drain;
        do_reset;
        bus.req_valid[0] = 1'b1;
        bus.req_data[0 +: DW] = 32'hA0;
        step;
        step;
        step;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== 4'b0001) begin
                failures++; $display("FAIL drain_grant k=%0d got %b want 0001", k, bus.req_ready);
            end
            step;
            bus.req_data[0 +: DW] = DW'(32'hA1 + k);
        end
        bus.req_valid = '0;
        @(negedge clk);
        checks++;
        if (dut.state !== 2'd2 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL drain_run got state=%0d busy=%b want 2 1", dut.state, bus.busy);
        end
        step;
        @(negedge clk);
        checks++;
        if (dut.state !== 2'd3) begin
            failures++; $display("FAIL drain_state got %0d want 3", dut.state);
        end
        step;
        step;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.u_start !== 1'b1) begin
            failures++; $display("FAIL drain_hold got busy=%b start=%b want 1 1", bus.busy, bus.u_start);
        end
        step;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.u_start !== 1'b0 || dut.state !== 2'd0) begin
            failures++;
            $display("FAIL drain_idle got busy=%b start=%b state=%0d want 0 0 0",
                     bus.busy, bus.u_start, dut.state);
        end
        checks++;
        if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_data[0 +: DW] !== ~32'hA0) begin
            failures++;
            $display("FAIL drain_rsp got valid=%b data=%h want 1 %h",
                     bus.rsp_valid[0], bus.rsp_data[0 +: DW], ~32'hA0);
        end
    endtask

    task automatic test_error;
        do_reset;
        bus.req_valid[0] = 1'b1;
        bus.req_data[0 +: DW] = 32'h4000_0000;
        step;
        step;
        step;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++; $display("FAIL err_grant got %b want 0001", bus.req_ready);
        end
        step;
        bus.req_valid = '0;
        step;
        step;
        step;
        kill = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b0) begin
            failures++; $display("FAIL err_early got %b want 0", bus.err);
        end
        step;
        kill = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b1) begin
            failures++; $display("FAIL err_set got %b want 1", bus.err);
        end
        checks++;
        if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_data[0 +: DW] !== 32'hBFFF_FFFF) begin
            failures++;
            $display("FAIL err_write got valid=%b data=%h want 1 bfffffff",
                     bus.rsp_valid[0], bus.rsp_data[0 +: DW]);
        end
        repeat (10) step;
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b1) begin
            failures++; $display("FAIL err_sticky got %b want 1", bus.err);
        end
        do_reset;
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b0) begin
            failures++; $display("FAIL err_clear got %b want 0", bus.err);
        end
    endtask

    task automatic test_reset_mid;
        int stale = 0;
        do_reset;
        bus.req_valid = 4'b0111;
        bus.req_data  = {32'h0, 32'h22, 32'h11, 32'h00};
        step;
        step;
        step;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== (N'(1) << k)) begin
                failures++;
                $display("FAIL mid_grant k=%0d got %b want %b", k, bus.req_ready, N'(1) << k);
            end
            step;
        end
        rst = 1'b1;
        bus.req_valid = '0;
        step;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.u_start, bus.busy, bus.err} !== '0
            || bus.u_x !== '0 || bus.rsp_data !== '0) begin
            failures++;
            $display("FAIL mid_outputs got ready=%b valid=%b start=%b busy=%b err=%b x=%h want 0",
                     bus.req_ready, bus.rsp_valid, bus.u_start, bus.busy, bus.err, bus.u_x);
        end
        for (int k = 0; k < 8; k++) begin
            step;
            @(negedge clk);
            if (bus.rsp_valid !== 4'b0) stale++;
        end
        checks++;
        if (stale !== 0) begin
            failures++; $display("FAIL mid_stale got %0d want 0", stale);
        end
        step;
        bus.req_valid = 4'b1111;
        step;
        step;
        step;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++; $display("FAIL mid_first got %b want 0001", bus.req_ready);
        end
        step;
        bus.req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_backpressure;
        test_drain;
        test_error;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tanhx_share_ctrl.md
# tanhx_share_ctrl

Controller that shares one pipelined tanh unit among N requesters. It round-robin arbitrates valid/ready operand requests and sequences the unit's start/warm-up protocol. It tracks every in-flight operand with a tag pipeline and returns each result to the requester that issued it, through a per-requester result FIFO. It sits between the activation-function clients and the single `tanhx_12_hw` instance.

## Interface
- N, 4: number of requesters (2..8)
- DWIDTH, 32: operand/result width (IEEE-754 single)
- LAT, 4: cycles from operand sample to unit result
- WARM, 2: dummy start cycles after the unit leaves idle
- DEPTH, 4: result FIFO entries per requester (DEPTH ≥ 1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  N  operand offered by requester i
- req_data  in  N*DWIDTH  operands; requester i at bits [i*DWIDTH +: DWIDTH]
- req_ready  out  N  one-hot grant; operand accepted when valid&ready
- rsp_valid  out  N  result available for requester i
- rsp_data  out  N*DWIDTH  FIFO head per requester
- rsp_ready  in  N  requester i pops its head
- u_start  out  1  start to tanh unit
- u_x  out  DWIDTH  operand to tanh unit
- u_y  in  DWIDTH  unit result
- u_valid  in  1  unit valid
- busy  out  1  state ≠ IDLE
- err  out  1  sticky: expected result arrived with u_valid low

## Operation
- Eligibility: requester i is eligible when req_valid[i] is high and credit[i] < DEPTH. credit[i] counts in-flight plus buffered results.
- Arbitration: round-robin. The search starts at last_grant+1 mod N and grants the first eligible requester. At most one grant per cycle, and only in RUN or DRAIN.
- Credit update: +1 on grant, −1 on pop; both in the same cycle leaves it unchanged. The credit rule guarantees no FIFO overflow, so no overflow check is needed.
- Grant cycle: u_x = granted operand, and the tag pipeline input is {1, i}. A non-grant cycle drives u_x = 0 and tag {0, x}.
- Tag pipeline: LAT stages. On a stage-LAT valid tag, the controller writes u_y into FIFO[tag]. If u_valid is 0 at that point it still writes, and sets err.
- FSM:
  - IDLE: u_start=0, no grants. Goes to WARM when any req_valid is high with credit < DEPTH.
  - WARM: u_start=1, u_x=0, counts WARM cycles, then goes to RUN.
  - RUN: u_start=1, grants. A cycle with no grant goes to DRAIN.
  - DRAIN: u_start=1, grants allowed. A grant returns to RUN. If there is no grant and the tag pipeline is empty after this cycle, go to IDLE.
- FIFO: simultaneous write and pop on the same FIFO are both honoured. Write-through from empty is not allowed: rsp_valid rises the cycle after the write.

## Timing
- A grant in cycle c means u_x/u_start are driven in c; the result is captured at the end of c+LAT; rsp_valid is high from c+LAT+1.
- First grant after IDLE: the request is seen in cycle c0, WARM occupies c0+1..c0+WARM, and the earliest grant is c0+WARM+1.
- Back-to-back grants give one issue per cycle in steady RUN.
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, u_start=0, u_x=0, busy=0, err=0.
  - State IDLE, tags invalid, FIFOs empty, credits 0, last_grant=N−1, so requester 0 has first priority.
- Reset mid-operation: all in-flight tags and buffered results are discarded. No rsp_valid in the cycle after rst deasserts. The unit shares rst.
- A requester that never pops stalls only itself once credit=DEPTH; the others continue.

## Test plan
- Single request: requester 2 offers 0x3F800000 (1.0) from IDLE. Grant at cycle c0+3 (WARM=2); rsp_valid[2] at grant+5 with unit result, err=0.
- Round-robin: all 4 requesters valid continuously with rsp_ready=1. Grants go 0,1,2,3,0,… one per cycle; each requester gets results in issue order.
- Backpressure: requester 1 continuous with rsp_ready[1]=0. Exactly 4 grants, then req_ready[1]=0 while requester 3 keeps being served. Releasing rsp_ready gives 4 pops and granting resumes.
- Drain/idle: a burst of 3 grants then no requests. State goes RUN→DRAIN, reaches IDLE after the last result is captured, u_start=0 and busy=0 after that.
- Error flag: force u_valid=0 on the cycle a tagged result returns. err=1 and stays 1 until rst.
- Reset mid-burst: rst for 1 cycle with 3 operands in flight. All outputs at reset values, no stale rsp_valid, and the next request is granted to requester 0 first.
